// File: rtl/ic_dest_part_buf_pkg.sv
// Shared nexthop field layout, flit width and helper functions for the destination partition.
// A nexthop is {partition id, fully-qualified queue id (node 4 bits + port 3 bits)}.
package ic_dest_part_buf_pkg;

  localparam int FLIT_WIDTH = 32;
  localparam int A_FQID_W   = 7;
  localparam int A_FQID_LSB = 0;
  localparam int A_PID_W    = 3;
  localparam int A_PID_LSB  = A_FQID_LSB + A_FQID_W;
  localparam int A_WIDTH    = A_PID_LSB + A_PID_W;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      result = ((32'sd1 <<< i) < value) ? (i + 1) : result;
    end
    return result;
  endfunction

  function automatic logic [A_PID_W-1:0] nh_pid(input logic [A_WIDTH-1:0] nexthop);
    return nexthop[A_PID_LSB +: A_PID_W];
  endfunction

  function automatic logic [A_FQID_W-1:0] nh_fqid(input logic [A_WIDTH-1:0] nexthop);
    return nexthop[A_FQID_LSB +: A_FQID_W];
  endfunction

endpackage

// File: rtl/ic_dest_part_buf_if.sv
// Source-side request/grant/flit bus and node-side FIFO head bus of a destination partition.
interface ic_dest_part_buf_if
  import ic_dest_part_buf_pkg::*;
#(
  parameter int NSP   = 8,
  parameter int WIDTH = FLIT_WIDTH,
  parameter int DEPTH = 4
);

  logic [NSP-1:0]           src_s1_valid;
  logic [NSP-1:0]           src_s1_valid_urgent;
  logic [NSP*A_WIDTH-1:0]   src_s1_nexthop_in;
  logic [NSP-1:0]           src_s1_part_sel;
  logic [NSP*WIDTH-1:0]     src_s2_data_in;
  logic [NSP*A_WIDTH-1:0]   src_s2_nexthop_in;
  logic                     dequeue;
  logic [WIDTH-1:0]         s3_data_out;
  logic [A_FQID_W-1:0]      s3_nexthop_out;
  logic                     s3_data_valid;
  logic [clog2(DEPTH+1)-1:0] s3_count;

  modport slave (
    input  src_s1_valid, src_s1_valid_urgent, src_s1_nexthop_in,
    input  src_s2_data_in, src_s2_nexthop_in, dequeue,
    output src_s1_part_sel, s3_data_out, s3_nexthop_out, s3_data_valid, s3_count
  );

  modport master (
    output src_s1_valid, src_s1_valid_urgent, src_s1_nexthop_in,
    output src_s2_data_in, src_s2_nexthop_in, dequeue,
    input  src_s1_part_sel, s3_data_out, s3_nexthop_out, s3_data_valid, s3_count
  );

endinterface

// File: rtl/ic_dest_part_buf_rr_select_urgent.sv
// Two-level round-robin picker: urgent requests win over normal ones, and within the
// chosen set the first request at or after the pointer is granted.
module rr_select_urgent
  import ic_dest_part_buf_pkg::*;
#(
  parameter  int N  = 8,
  localparam int IW = clog2(N)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_allow,
  input  logic [N-1:0]  i_req,
  input  logic [N-1:0]  i_urg,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);

  logic [IW-1:0] r_rr;
  logic [N-1:0]  w_set;
  logic [N-1:0]  w_one;

  assign w_one = {{(N-1){1'b0}}, 1'b1};

  // scan the selected set starting at the pointer, wrapping N-1 -> 0
  always_comb begin
    logic [IW:0] w_pos;
    logic        w_hit;
    w_set   = (|(i_req & i_urg)) ? (i_req & i_urg) : i_req;
    o_valid = 1'b0;
    o_idx   = '0;
    w_pos   = '0;
    w_hit   = 1'b0;
    for (int k = 0; k < N; k++) begin
      w_pos   = {1'b0, r_rr} + (IW+1)'(k);
      w_pos   = (w_pos >= (IW+1)'(N)) ? (w_pos - (IW+1)'(N)) : w_pos;
      w_hit   = i_allow && !o_valid && w_set[w_pos[IW-1:0]];
      o_idx   = w_hit ? w_pos[IW-1:0] : o_idx;
      o_valid = o_valid | w_hit;
    end
    o_gnt = o_valid ? (w_one << o_idx) : '0;
  end

  // pointer moves just past the granted source, holds otherwise
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rr <= '0;
    end else if (o_valid) begin
      r_rr <= (o_idx == IW'(N-1)) ? '0 : (o_idx + IW'(1));
    end else begin
      r_rr <= r_rr;
    end
  end

endmodule

// File: rtl/ic_dest_part_buf.sv
// Destination interconnect partition: credit-gated urgent-first arbitration over source
// partitions, one-cycle stage-2 capture, and a show-ahead output FIFO toward the node.
module ic_dest_part_buf
  import ic_dest_part_buf_pkg::*;
#(
  parameter int PID   = 0,
  parameter int NSP   = 8,
  parameter int WIDTH = FLIT_WIDTH,
  parameter int PID_W = A_PID_W,
  parameter int DEPTH = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  output logic                error,
  ic_dest_part_buf_if.slave   bus
);

  localparam int SEL_W = clog2(NSP);
  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = clog2(DEPTH+1);
  localparam int ENT_W = WIDTH + A_FQID_W;

  logic [NSP-1:0]      w_elig;
  logic [NSP-1:0]      w_urg;
  logic                w_allow;
  logic [NSP-1:0]      w_gnt;
  logic [SEL_W-1:0]    w_gnt_idx;
  logic                w_gnt_valid;
  logic [WIDTH-1:0]    w_data_arr [NSP];
  logic [A_FQID_W-1:0] w_fqid_arr [NSP];

  logic [SEL_W-1:0]    r_sel;
  logic                r_sel_valid;
  logic [ENT_W-1:0]    r_mem [DEPTH];
  logic [PTR_W-1:0]    r_wr;
  logic [PTR_W-1:0]    r_rd;
  logic [CNT_W-1:0]    r_count;
  logic                r_error;

  logic                w_empty;
  logic                w_full;
  logic                w_pop;
  logic                w_push;
  logic                w_write;
  logic [ENT_W-1:0]    w_head;

  // per-source destination check and unpacking of the stage-2 buses
  always_comb begin
    for (int i = 0; i < NSP; i++) begin
      w_elig[i] = bus.src_s1_valid[i] &&
                  (nh_pid(bus.src_s1_nexthop_in[i*A_WIDTH +: A_WIDTH]) == PID_W'(PID));
      w_data_arr[i] = bus.src_s2_data_in[i*WIDTH +: WIDTH];
      w_fqid_arr[i] = nh_fqid(bus.src_s2_nexthop_in[i*A_WIDTH +: A_WIDTH]);
    end
    w_urg = w_elig & bus.src_s1_valid_urgent;
  end

  // a grant needs a free slot counting both stored and in-flight flits; a pop this cycle is ignored
  assign w_allow = enable && !reset &&
                   (({1'b0, r_count} + (CNT_W+1)'(r_sel_valid)) < (CNT_W+1)'(DEPTH));

  rr_select_urgent #(.N(NSP)) u_pick (
    .clock   (clock),
    .reset   (reset),
    .i_allow (w_allow),
    .i_req   (w_elig),
    .i_urg   (w_urg),
    .o_gnt   (w_gnt),
    .o_idx   (w_gnt_idx),
    .o_valid (w_gnt_valid)
  );

  assign bus.src_s1_part_sel = w_gnt;

  // stage-2 select register; an in-flight capture completes regardless of enable
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sel       <= '0;
      r_sel_valid <= 1'b0;
    end else begin
      r_sel       <= w_gnt_valid ? w_gnt_idx : r_sel;
      r_sel_valid <= w_gnt_valid;
    end
  end

  assign w_empty = (r_count == CNT_W'(0));
  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_pop   = bus.dequeue && !w_empty;
  assign w_push  = r_sel_valid;
  assign w_write = w_push && (!w_full || w_pop);

  // FIFO storage
  always_ff @(posedge clock) begin
    if (w_write) begin
      r_mem[r_wr] <= {w_fqid_arr[r_sel], w_data_arr[r_sel]};
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      r_wr <= w_write ? (r_wr + PTR_W'(1)) : r_wr;
      r_rd <= w_pop   ? (r_rd + PTR_W'(1)) : r_rd;
      case ({w_write, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // sticky protocol error
  always_ff @(posedge clock) begin
    if (reset) begin
      r_error <= 1'b0;
    end else if ((bus.dequeue && w_empty) || (w_push && w_full && !w_pop)) begin
      r_error <= 1'b1;
    end else begin
      r_error <= r_error;
    end
  end

  assign w_head            = r_mem[r_rd];
  assign error             = r_error;
  assign bus.s3_data_valid = !w_empty;
  assign bus.s3_count      = r_count;
  assign bus.s3_data_out   = w_empty ? '0 : w_head[WIDTH-1:0];
  assign bus.s3_nexthop_out = w_empty ? '0 : w_head[ENT_W-1:WIDTH];

endmodule

// File: tb/tb_ic_dest_part_buf.sv
// Directed-vector bench for ic_dest_part_buf (PID=2, NSP=8, DEPTH=4); source 7 targets another partition.
module tb_ic_dest_part_buf;
  import ic_dest_part_buf_pkg::*;

  localparam int NSP = 8;
  localparam int W   = 32;
  localparam int DEP = 4;

  logic clock;
  logic reset;
  logic enable;
  logic error;
  int   n_tests;
  int   n_fail;

  ic_dest_part_buf_if #(.NSP(NSP), .WIDTH(W), .DEPTH(DEP)) bus ();

  ic_dest_part_buf #(.PID(2), .NSP(NSP), .WIDTH(W), .PID_W(3), .DEPTH(DEP)) dut (
    .clock  (clock),
    .reset  (reset),
    .enable (enable),
    .error  (error),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] flit(input int i);
    return 32'hD000_0000 + 32'(i) * 32'h0000_0111;
  endfunction

  function automatic logic [6:0] fq(input int i);
    return 7'h10 + 7'(i);
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.src_s1_valid = '0;
    bus.src_s1_valid_urgent = '0;
    bus.dequeue = 1'b0;
    enable = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seq [3];
    logic [7:0] exp_sel [6];
    logic [2:0] exp_cnt [3];
    n_tests = 0;
    n_fail  = 0;
    seq = '{1, 4, 6};
    exp_sel = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h00, 8'h00};
    exp_cnt = '{3'd0, 3'd1, 3'd1};
    for (int i = 0; i < NSP; i++) begin
      bus.src_s2_data_in[i*W +: W] = flit(i);
      bus.src_s1_nexthop_in[i*A_WIDTH +: A_WIDTH] = {(i == 7) ? 3'd3 : 3'd2, fq(i)};
      bus.src_s2_nexthop_in[i*A_WIDTH +: A_WIDTH] = {(i == 7) ? 3'd3 : 3'd2, fq(i)};
    end

    // reset state, with requests present during reset
    reset = 1'b1;
    enable = 1'b1;
    bus.dequeue = 1'b0;
    bus.src_s1_valid = 8'h7F;
    bus.src_s1_valid_urgent = '0;
    step();
    step();
    chk("rst_part_sel", 64'(bus.src_s1_part_sel), 64'h0);
    chk("rst_error", 64'(error), 64'h0);
    chk("rst_valid", 64'(bus.s3_data_valid), 64'h0);
    chk("rst_count", 64'(bus.s3_count), 64'h0);
    chk("rst_data", 64'(bus.s3_data_out), 64'h0);
    chk("rst_nh", 64'(bus.s3_nexthop_out), 64'h0);
    do_reset();

    // single source 3, latency to FIFO head
    bus.src_s1_valid = 8'h08;
    #1 chk("single_sel", 64'(bus.src_s1_part_sel), 64'h08);
    step();
    bus.src_s1_valid = 8'h00;
    #1 chk("single_sel_t1", 64'(bus.src_s1_part_sel), 64'h00);
    chk("single_valid_t1", 64'(bus.s3_data_valid), 64'h0);
    step();
    chk("single_valid_t2", 64'(bus.s3_data_valid), 64'h1);
    chk("single_data", 64'(bus.s3_data_out), 64'(flit(3)));
    chk("single_nh", 64'(bus.s3_nexthop_out), 64'(fq(3)));
    chk("single_count", 64'(bus.s3_count), 64'h1);
    bus.dequeue = 1'b1;
    step();
    bus.dequeue = 1'b0;
    chk("single_drain", 64'(bus.s3_count), 64'h0);

    // round robin over sources 1,4,6 with continuous draining
    do_reset();
    bus.src_s1_valid = 8'b0101_0010;
    for (int c = 0; c < 9; c++) begin
      bus.dequeue = (c >= 2);
      #1 chk("rr_sel", 64'(bus.src_s1_part_sel), 64'(8'h01 << seq[c % 3]));
      if (c >= 2) begin
        chk("rr_valid", 64'(bus.s3_data_valid), 64'h1);
        chk("rr_data", 64'(bus.s3_data_out), 64'(flit(seq[(c-2) % 3])));
      end
      step();
    end
    bus.dequeue = 1'b0;

    // urgent beats normal, pointer lands after the urgent source
    do_reset();
    bus.src_s1_valid = 8'h24;
    bus.src_s1_valid_urgent = 8'h20;
    #1 chk("urg_sel", 64'(bus.src_s1_part_sel), 64'h20);
    step();
    bus.src_s1_valid = 8'h04;
    bus.src_s1_valid_urgent = 8'h00;
    #1 chk("urg_next", 64'(bus.src_s1_part_sel), 64'h04);
    step();
    bus.src_s1_valid = 8'h12;
    #1 chk("urg_ptr", 64'(bus.src_s1_part_sel), 64'h10);

    // credit gating fills exactly DEPTH entries
    do_reset();
    bus.src_s1_valid = 8'hFF;
    for (int c = 0; c < 6; c++) begin
      #1 chk("full_sel", 64'(bus.src_s1_part_sel), 64'(exp_sel[c]));
      step();
    end
    chk("full_count", 64'(bus.s3_count), 64'h4);
    chk("full_error", 64'(error), 64'h0);
    chk("full_head", 64'(bus.s3_data_out), 64'(flit(0)));
    bus.dequeue = 1'b1;
    #1 chk("full_deq_sel", 64'(bus.src_s1_part_sel), 64'h00);
    step();
    bus.dequeue = 1'b0;
    #1 chk("full_regrant", 64'(bus.src_s1_part_sel), 64'h10);
    chk("full_count3", 64'(bus.s3_count), 64'h3);
    chk("full_head1", 64'(bus.s3_data_out), 64'(flit(1)));
    step();
    chk("full_hold", 64'(bus.src_s1_part_sel), 64'h00);
    step();
    chk("full_count4", 64'(bus.s3_count), 64'h4);
    chk("full_hold2", 64'(bus.src_s1_part_sel), 64'h00);

    // foreign partition never granted; enable low blocks grants but not in-flight push
    do_reset();
    bus.src_s1_valid = 8'h80;
    for (int c = 0; c < 3; c++) begin
      #1 chk("foreign_sel", 64'(bus.src_s1_part_sel), 64'h00);
      step();
    end
    bus.src_s1_valid = 8'h01;
    #1 chk("en_grant", 64'(bus.src_s1_part_sel), 64'h01);
    step();
    enable = 1'b0;
    bus.src_s1_valid = 8'h03;
    for (int c = 0; c < 3; c++) begin
      #1 chk("en_off_sel", 64'(bus.src_s1_part_sel), 64'h00);
      chk("en_off_count", 64'(bus.s3_count), 64'(exp_cnt[c]));
      step();
    end
    enable = 1'b1;
    #1 chk("en_resume", 64'(bus.src_s1_part_sel), 64'h02);
    chk("en_data", 64'(bus.s3_data_out), 64'(flit(0)));

    // dequeue on empty sets sticky error
    do_reset();
    chk("err_clear", 64'(error), 64'h0);
    bus.dequeue = 1'b1;
    step();
    bus.dequeue = 1'b0;
    chk("err_set", 64'(error), 64'h1);
    step();
    chk("err_sticky", 64'(error), 64'h1);

    // reset mid-stream drops everything, arbitration resumes from pointer 0
    bus.src_s1_valid = 8'h06;
    step();
    step();
    step();
    reset = 1'b1;
    #1 chk("mid_rst_sel", 64'(bus.src_s1_part_sel), 64'h00);
    step();
    chk("mid_rst_err", 64'(error), 64'h0);
    chk("mid_rst_valid", 64'(bus.s3_data_valid), 64'h0);
    chk("mid_rst_count", 64'(bus.s3_count), 64'h0);
    chk("mid_rst_data", 64'(bus.s3_data_out), 64'h0);
    chk("mid_rst_nh", 64'(bus.s3_nexthop_out), 64'h0);
    reset = 1'b0;
    #1 chk("mid_resume", 64'(bus.src_s1_part_sel), 64'h02);
    step();
    bus.src_s1_valid = 8'h00;
    step();
    chk("mid_count", 64'(bus.s3_count), 64'h1);
    chk("mid_data", 64'(bus.s3_data_out), 64'(flit(1)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
